// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: core port, accelerator port and dmem port.
// slave = arbiter view, master = requester/memory side view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byte_en;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        acc_req;
  logic        acc_lock;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_byte_en;
  logic        acc_gnt;
  logic [31:0] acc_rdata;
  logic        acc_rvalid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_byte_en,
    input  acc_req, acc_lock, acc_addr, acc_wdata,
    input  acc_byte_en, mem_rdata,
    output cpu_stall, cpu_rdata, acc_gnt, acc_rdata,
    output acc_rvalid, mem_addr, mem_wdata,
    output mem_byte_en, mem_read
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_byte_en,
    output acc_req, acc_lock, acc_addr, acc_wdata,
    output acc_byte_en, mem_rdata,
    input  cpu_stall, cpu_rdata, acc_gnt, acc_rdata,
    input  acc_rvalid, mem_addr, mem_wdata,
    input  mem_byte_en, mem_read
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares dmem between the core LSU (static priority) and the accelerator.
// Ports: clk, reset (sync active-low), bus (slave: cpu_*, acc_*, mem_*).
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_ACC,
    S_LOCK
  } state_e;

  state_e      state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic        gnt_cpu;
  logic        gnt_acc;
  logic        hold;
  logic [3:0]  sel_be;

  // Grant decision; grants are suppressed while reset is held low.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_acc = 1'b0;
    hold    = 1'b0;
    if (reset) begin
      if (state_q == S_LOCK && bus.acc_req &&
          lock_q < LW'(LOCK_MAX)) begin
        gnt_acc = 1'b1;
        hold    = 1'b1;
      end else if (bus.acc_req &&
                   wait_q == WW'(MAX_WAIT)) begin
        gnt_acc = 1'b1;
      end else if (bus.cpu_req) begin
        gnt_cpu = 1'b1;
      end else if (bus.acc_req) begin
        gnt_acc = 1'b1;
      end
    end
  end

  // Next state, counters and accelerator read capture.
  always_comb begin
    state_d  = S_IDLE;
    wait_d   = '0;
    lock_d   = '0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    if (gnt_acc) begin
      state_d = bus.acc_lock ? S_LOCK : S_ACC;
    end else if (gnt_cpu) begin
      state_d = S_CPU;
    end

    if (bus.acc_req && !gnt_acc) begin
      if (wait_q == WW'(MAX_WAIT)) begin
        wait_d = wait_q;
      end else begin
        wait_d = wait_q + WW'(1);
      end
    end

    // Only a rule-1 grant extends a lock; any other way in restarts at 1.
    if (state_d == S_LOCK) begin
      lock_d = hold ? lock_q + LW'(1) : LW'(1);
    end

    if (gnt_acc && bus.acc_byte_en == 4'b0000) begin
      rdata_d  = bus.mem_rdata;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      lock_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Memory port mux.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    sel_be        = 4'b0000;
    if (gnt_acc) begin
      bus.mem_addr  = bus.acc_addr;
      bus.mem_wdata = bus.acc_wdata;
      sel_be        = bus.acc_byte_en;
    end else if (gnt_cpu) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      sel_be        = bus.cpu_byte_en;
    end
  end

  assign bus.mem_byte_en = sel_be;
  assign bus.mem_read    = (gnt_acc | gnt_cpu) &
                           (sel_be == 4'b0000);
  assign bus.cpu_stall   = reset & bus.cpu_req & ~gnt_cpu;
  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.acc_gnt     = gnt_acc;
  assign bus.acc_rdata   = rdata_q;
  assign bus.acc_rvalid  = rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small dmem model.
// Expected accelerator read data flows through a scoreboard queue.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(
    .MAX_WAIT(4),
    .LOCK_MAX(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // dmem model: unwritten words read as A500_00<index>.
  logic [31:0]  ram [256];
  logic [255:0] wr = '0;
  logic [7:0]   idx;
  logic [31:0]  merged;

  always_comb begin
    idx = bus.mem_addr[9:2];
    bus.mem_rdata = wr[idx] ? ram[idx] :
                    (32'hA500_0000 | {24'h0, idx});
    merged = bus.mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_en[b]) begin
        merged[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (|bus.mem_byte_en) begin
      ram[idx] <= merged;
      wr[idx]  <= 1'b1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  task automatic drive(
    input bit rn,
    input bit cr, input logic [31:0] ca,
    input logic [31:0] cd, input logic [3:0] cb,
    input bit ar, input bit al, input logic [31:0] aa,
    input logic [31:0] ad, input logic [3:0] ab
  );
    @(posedge clk);
    #1;
    reset           = rn;
    bus.cpu_req     = cr;
    bus.cpu_addr    = ca;
    bus.cpu_wdata   = cd;
    bus.cpu_byte_en = cb;
    bus.acc_req     = ar;
    bus.acc_lock    = al;
    bus.acc_addr    = aa;
    bus.acc_wdata   = ad;
    bus.acc_byte_en = ab;
    #1;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int c = 1; c <= 3; c++) begin
      drive(0, 1, 32'h104, 32'h1111_1111, 4'hF,
            1, 1, 32'h200, 32'h2222_2222, 4'hF);
      n_vec++;
      if (bus.acc_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL rst_acc_gnt c%0d got=%b exp=0", c, bus.acc_gnt);
      end
      n_vec++;
      if (bus.cpu_stall !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stall c%0d got=%b exp=0", c, bus.cpu_stall);
      end
      n_vec++;
      if (bus.mem_byte_en !== 4'h0 || bus.mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mem c%0d be=%h rd=%b exp=0/0",
                 c, bus.mem_byte_en, bus.mem_read);
      end
    end
    idle();
    n_vec++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
        bus.mem_byte_en !== 4'h0 || bus.mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL idle_mem addr=%h wd=%h be=%h rd=%b exp=all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_byte_en,
               bus.mem_read);
    end
    n_vec++;
    if (bus.acc_rvalid !== 1'b0 || bus.acc_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL idle_acc rv=%b rd=%h exp=0/0",
               bus.acc_rvalid, bus.acc_rdata);
    end
    n_vec++;
    if (bus.acc_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL idle_gnt gnt=%b stall=%b exp=0/0",
               bus.acc_gnt, bus.cpu_stall);
    end
  endtask

  task automatic test_cpu_alone();
    drive(1, 1, 32'h104, 32'h0000_5A00, 4'b0010, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.mem_byte_en !== 4'b0010 || bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_wr be=%b stall=%b exp=0010/0",
               bus.mem_byte_en, bus.cpu_stall);
    end
    n_vec++;
    if (bus.mem_addr !== 32'h104 || bus.mem_wdata !== 32'h5A00 ||
        bus.mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_wr_bus addr=%h wd=%h rd=%b exp=104/5a00/0",
               bus.mem_addr, bus.mem_wdata, bus.mem_read);
    end
    drive(1, 1, 32'h104, 0, 4'b0000, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.mem_read !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_rd rd=%b stall=%b exp=1/0",
               bus.mem_read, bus.cpu_stall);
    end
    n_vec++;
    if (bus.cpu_rdata !== 32'hA500_5A41) begin
      n_err++;
      $display("FAIL cpu_rdata got=%h exp=a5005a41", bus.cpu_rdata);
    end
    idle();
  endtask

  task automatic test_starvation();
    bit g;
    for (int c = 1; c <= 5; c++) begin
      drive(1, 1, 32'h10, 0, 0, 1, 0, 32'h200, 0, 0);
      g = (c == 5);
      n_vec++;
      if (bus.acc_gnt !== g || bus.cpu_stall !== g) begin
        n_err++;
        $display("FAIL starve c%0d gnt=%b stall=%b exp=%b/%b",
                 c, bus.acc_gnt, bus.cpu_stall, g, g);
      end
      if (g) begin
        sb.push_back(32'hA500_0080);
        n_vec++;
        if (bus.mem_addr !== 32'h200 || bus.mem_read !== 1'b1) begin
          n_err++;
          $display("FAIL starve_bus addr=%h rd=%b exp=200/1",
                   bus.mem_addr, bus.mem_read);
        end
      end
    end
    drive(1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.acc_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL starve_c6 gnt=%b stall=%b exp=0/0",
               bus.acc_gnt, bus.cpu_stall);
    end
    n_vec++;
    if (bus.acc_rvalid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL starve_rvalid got=%b exp=1 q=%0d",
               bus.acc_rvalid, sb.size());
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.acc_rdata !== e) begin
        n_err++;
        $display("FAIL starve_rdata got=%h exp=%h", bus.acc_rdata, e);
      end
    end
    idle();
    n_vec++;
    if (bus.acc_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL starve_pulse got=%b exp=0", bus.acc_rvalid);
    end
  endtask

  task automatic test_lock_rmw();
    int stalls = 0;
    for (int c = 1; c <= 5; c++) begin
      drive(1, 1, 32'h10, 0, 0, 1, 1, 32'h300, 0, 0);
      stalls += int'(bus.cpu_stall);
      n_vec++;
      if (bus.acc_gnt !== (c == 5)) begin
        n_err++;
        $display("FAIL rmw_rd c%0d gnt=%b exp=%b",
                 c, bus.acc_gnt, c == 5);
      end
    end
    sb.push_back(32'hA500_00C0);
    drive(1, 1, 32'h10, 0, 0, 1, 0, 32'h300, 32'hA500_00C1, 4'hF);
    stalls += int'(bus.cpu_stall);
    n_vec++;
    if (bus.acc_gnt !== 1'b1 || bus.mem_byte_en !== 4'hF ||
        bus.mem_wdata !== 32'hA500_00C1) begin
      n_err++;
      $display("FAIL rmw_wr gnt=%b be=%h wd=%h exp=1/f/a50000c1",
               bus.acc_gnt, bus.mem_byte_en, bus.mem_wdata);
    end
    n_vec++;
    if (bus.acc_rvalid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL rmw_rvalid got=%b exp=1 q=%0d",
               bus.acc_rvalid, sb.size());
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.acc_rdata !== e) begin
        n_err++;
        $display("FAIL rmw_rdata got=%h exp=%h", bus.acc_rdata, e);
      end
    end
    drive(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    stalls += int'(bus.cpu_stall);
    n_vec++;
    if (stalls != 2) begin
      n_err++;
      $display("FAIL rmw_stalls got=%0d exp=2", stalls);
    end
    n_vec++;
    if (bus.cpu_rdata !== 32'hA500_00C1 || bus.acc_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_result rdata=%h rv=%b exp=a50000c1/0",
               bus.cpu_rdata, bus.acc_rvalid);
    end
    idle();
  endtask

  task automatic test_lock_max();
    bit g;
    bit pg = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      if (c <= 18) begin
        drive(1, 1, 32'h10, 0, 0, 1, 1, 32'h380, 0, 0);
        g = (c >= 5 && c <= 12) || c >= 17;
      end else begin
        drive(1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        g = 1'b0;
      end
      n_vec++;
      if (bus.acc_gnt !== g || bus.cpu_stall !== g) begin
        n_err++;
        $display("FAIL lockmax c%0d gnt=%b stall=%b exp=%b/%b",
                 c, bus.acc_gnt, bus.cpu_stall, g, g);
      end
      n_vec++;
      if (bus.acc_rvalid !== pg) begin
        n_err++;
        $display("FAIL lockmax_rv c%0d got=%b exp=%b",
                 c, bus.acc_rvalid, pg);
      end else if (pg && sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        if (bus.acc_rdata !== e) begin
          n_err++;
          $display("FAIL lockmax_rd c%0d got=%h exp=%h",
                   c, bus.acc_rdata, e);
        end
      end
      if (g) sb.push_back(32'hA500_00E0);
      pg = g;
    end
    idle();
  endtask

  task automatic test_reset_lock();
    drive(1, 0, 0, 0, 0, 1, 1, 32'h340, 0, 0);
    n_vec++;
    if (bus.acc_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rstlock_gnt got=%b exp=1", bus.acc_gnt);
    end
    sb.push_back(32'hA500_00D0);
    drive(0, 1, 32'h10, 0, 0, 1, 1, 32'h340, 32'hDEAD_BEEF, 4'hF);
    n_vec++;
    if (bus.acc_gnt !== 1'b0 || bus.mem_byte_en !== 4'h0 ||
        bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL rstlock_hold gnt=%b be=%h stall=%b exp=0/0/0",
               bus.acc_gnt, bus.mem_byte_en, bus.cpu_stall);
    end
    n_vec++;
    if (bus.acc_rvalid !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL rstlock_rvalid got=%b exp=1 q=%0d",
               bus.acc_rvalid, sb.size());
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.acc_rdata !== e) begin
        n_err++;
        $display("FAIL rstlock_rdata got=%h exp=%h", bus.acc_rdata, e);
      end
    end
    drive(1, 1, 32'h10, 0, 0, 1, 1, 32'h340, 32'hDEAD_BEEF, 4'hF);
    n_vec++;
    if (bus.cpu_stall !== 1'b0 || bus.acc_gnt !== 1'b0 ||
        bus.mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL rstlock_cpu stall=%b gnt=%b addr=%h exp=0/0/10",
               bus.cpu_stall, bus.acc_gnt, bus.mem_addr);
    end
    n_vec++;
    if (bus.acc_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rstlock_rvclr got=%b exp=0", bus.acc_rvalid);
    end
    drive(1, 1, 32'h340, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (bus.cpu_rdata !== 32'hA500_00D0) begin
      n_err++;
      $display("FAIL rstlock_mem got=%h exp=a50000d0", bus.cpu_rdata);
    end
    idle();
  endtask

  initial begin
    bus.cpu_req     = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.cpu_byte_en = '0;
    bus.acc_req     = 1'b0;
    bus.acc_lock    = 1'b0;
    bus.acc_addr    = '0;
    bus.acc_wdata   = '0;
    bus.acc_byte_en = '0;
    test_reset();
    test_cpu_alone();
    test_starvation();
    test_lock_rmw();
    test_lock_max();
    test_reset_lock();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
